// File: rtl/uart_rx_framed.sv
// Oversampling UART receiver with 3-sample majority vote, configurable framing, error and break
// detection, and a one-entry valid/ready output stage with sticky overrun.
module uart_rx_framed #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned CLK_RATE   = 12000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);

  localparam int unsigned DivRaw = CLK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned Div    = (DivRaw == 0) ? 1 : DivRaw;
  localparam int unsigned DivW   = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned SmpW   = $clog2(OVERSAMPLE);
  localparam int unsigned BitW   = $clog2(DATA_BITS);
  localparam int unsigned Mid    = OVERSAMPLE / 2;

  localparam logic [DivW-1:0] DivLast = DivW'(Div - 1);
  localparam logic [SmpW-1:0] SmpPre  = SmpW'(Mid - 1);
  localparam logic [SmpW-1:0] SmpMid  = SmpW'(Mid);
  localparam logic [SmpW-1:0] SmpPost = SmpW'(Mid + 1);
  localparam logic [SmpW-1:0] SmpLast = SmpW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);
  localparam logic            StopLast = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                 state_q, state_d;
  logic                   sync1_q, sync2_q, hist_q;
  logic [DivW-1:0]        div_q, div_d;
  logic [SmpW-1:0]        smp_q, smp_d;
  logic [BitW-1:0]        bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic                   s0_q, s0_d, s1_q, s1_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   perr_q, perr_d, ferr_q, ferr_d, par_q, par_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   perr_out_q, perr_out_d;
  logic                   ferr_out_q, ferr_out_d;
  logic                   brk_out_q, brk_out_d;
  logic                   ovr_q, ovr_d;

  logic fall, tick, vote, exp_par, commit, can_load, handshake;
  logic ferr_fin, brk_fin;

  assign fall    = hist_q & ~sync2_q;
  assign vote    = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);
  assign exp_par = (PARITY == 1) ? ~(^shreg_q) : ^shreg_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    smp_d   = smp_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    shreg_d = shreg_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    par_d   = par_q;
    tick    = 1'b0;
    commit  = 1'b0;

    if (state_q == StIdle) begin
      div_d  = '0;
      smp_d  = '0;
      bit_d  = '0;
      stop_d = 1'b0;
      if (fall) begin
        state_d = StStart;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        par_d   = 1'b0;
      end
    end else begin
      tick  = (div_q == DivLast);
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        smp_d = (smp_q == SmpLast) ? '0 : smp_q + 1'b1;
        if (smp_q == SmpPre) s0_d = sync2_q;
        if (smp_q == SmpMid) s1_d = sync2_q;
        case (state_q)
          StStart: begin
            if (smp_q == SmpPost && vote) state_d = StIdle;
            else if (smp_q == SmpLast)    state_d = StData;
          end
          StData: begin
            if (smp_q == SmpPost) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
            if (smp_q == SmpLast) begin
              if (bit_q == BitLast) begin
                bit_d   = '0;
                state_d = (PARITY != 0) ? StParity : StStop;
              end else begin
                bit_d = bit_q + 1'b1;
              end
            end
          end
          StParity: begin
            if (smp_q == SmpPost) begin
              par_d  = vote;
              perr_d = (vote != exp_par);
            end
            if (smp_q == SmpLast) state_d = StStop;
          end
          StStop: begin
            if (smp_q == SmpPost) begin
              ferr_d = ferr_q | ~vote;
              // Return to idle half a bit early so the next start edge is never missed.
              if (stop_q == StopLast) begin
                commit  = 1'b1;
                state_d = StIdle;
              end
            end else if (smp_q == SmpLast) begin
              stop_d = stop_q + 1'b1;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_comb begin
    ferr_fin   = ferr_q | ~vote;
    brk_fin    = (shreg_q == '0) && ((PARITY == 0) || !par_q) && ferr_fin;
    can_load   = ~valid_q | rx_ready;
    handshake  = valid_q & rx_ready;
    data_d     = data_q;
    valid_d    = valid_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    brk_out_d  = brk_out_q;
    ovr_d      = ovr_q;
    if (commit && can_load) begin
      data_d     = shreg_q;
      valid_d    = 1'b1;
      perr_out_d = (PARITY != 0) && perr_q;
      ferr_out_d = ferr_fin;
      brk_out_d  = brk_fin;
    end else if (handshake) begin
      valid_d = 1'b0;
    end
    if (commit && !can_load) ovr_d = 1'b1;
    else if (handshake)      ovr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      hist_q     <= 1'b1;
      div_q      <= '0;
      smp_q      <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      par_q      <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      brk_out_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= rx;
      sync2_q    <= sync1_q;
      hist_q     <= sync2_q;
      div_q      <= div_d;
      smp_q      <= smp_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      shreg_q    <= shreg_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      par_q      <= par_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      brk_out_q  <= brk_out_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_out_q;
  assign break_det  = brk_out_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed: an 8N1 and an 8E1 instance at 16 clk per bit, table vectors,
// hand-written corner sequences and randomized frames against a frame-level reference model.
module tb_uart_rx_framed;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_a, rx_b, rdy_a, rdy_b;
  logic [7:0] data_a, data_b;
  logic       val_a, val_b, pe_a, pe_b, fe_a, fe_b, bk_a, bk_b, ov_a, ov_b;

  always #5 clk = ~clk;

  uart_rx_framed #(
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
    .CLK_RATE(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16)
  ) u_dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .rx_data(data_a), .rx_valid(val_a), .rx_ready(rdy_a),
    .parity_err(pe_a), .frame_err(fe_a), .break_det(bk_a), .overrun(ov_a)
  );

  uart_rx_framed #(
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
    .CLK_RATE(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16)
  ) u_dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .rx_data(data_b), .rx_valid(val_b), .rx_ready(rdy_b),
    .parity_err(pe_b), .frame_err(fe_b), .break_det(bk_b), .overrun(ov_b)
  );

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       perr, ferr, brk, ovr;
  } out_t;

  typedef struct {
    logic [7:0] data;
    bit         par, stop;
    bit         e_perr, e_ferr, e_brk;
  } vec_t;

  int  n_pass = 0;
  int  n_total = 0;
  time t_start;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic out_t sample_out(input bit b);
    out_t o;
    o.valid = b ? val_b : val_a;
    o.data  = b ? data_b : data_a;
    o.perr  = b ? pe_b : pe_a;
    o.ferr  = b ? fe_b : fe_a;
    o.brk   = b ? bk_b : bk_a;
    o.ovr   = b ? ov_b : ov_a;
    return o;
  endfunction

  task automatic check_out(input string tag, input out_t o, input logic [7:0] d, input bit p,
                           input bit f, input bit k, input bit ov);
    check({tag, ".data"}, o.data, d);
    check({tag, ".parity_err"}, o.perr, p);
    check({tag, ".frame_err"}, o.ferr, f);
    check({tag, ".break_det"}, o.brk, k);
    check({tag, ".overrun"}, o.ovr, ov);
  endtask

  // Called and returns at posedge+1; holds the line level for n clocks.
  task automatic drive_bit(input bit b, input logic v, input int n);
    if (b) rx_b = v;
    else   rx_a = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit b, input logic [7:0] d, input bit pe, input bit pb,
                            input bit sb);
    t_start = $time;
    drive_bit(b, 1'b0, 16);
    for (int i = 0; i < 8; i++) drive_bit(b, d[i], 16);
    if (pe) drive_bit(b, pb, 16);
    drive_bit(b, sb, 16);
  endtask

  task automatic wait_valid(input bit b, input int max_cyc, output bit got, output out_t o,
                            output time t);
    got = 1'b0;
    t   = 0;
    o   = sample_out(b);
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk);
      o = sample_out(b);
      if (o.valid) begin
        got = 1'b1;
        t   = $time;
      end
    end
  endtask

  task automatic expect_quiet(input bit b, input int n, input string name);
    int seen = 0;
    out_t o;
    repeat (n) begin
      @(negedge clk);
      o = sample_out(b);
      if (o.valid) seen++;
    end
    check(name, seen, 0);
  endtask

  task automatic xfer(input bit b, input logic [7:0] d, input bit pe, input bit pb,
                      input bit sb, input string tag, input bit ep, input bit ef, input bit ek);
    bit   got;
    out_t o;
    time  t;
    fork
      send_frame(b, d, pe, pb, sb);
      begin
        wait_valid(b, 400, got, o, t);
        check({tag, ".got_valid"}, got, 1);
        if (got) check_out(tag, o, d, ep, ef, ek, 1'b0);
      end
    join
  endtask

  vec_t vecs[8];
  out_t o;
  bit   got;
  time  t_rise;
  int   lat;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // 8E1 vectors on instance B; expected flags worked out by hand.
    vecs[0] = '{8'h07, 1, 1, 0, 0, 0};
    vecs[1] = '{8'h07, 0, 1, 1, 0, 0};
    vecs[2] = '{8'h00, 0, 1, 0, 0, 0};
    vecs[3] = '{8'h00, 0, 0, 0, 1, 1};
    vecs[4] = '{8'h00, 1, 0, 1, 1, 0};
    vecs[5] = '{8'hFF, 0, 1, 0, 0, 0};
    vecs[6] = '{8'h80, 1, 0, 0, 1, 0};
    vecs[7] = '{8'h3C, 1, 1, 1, 0, 0};

    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      o = sample_out(b[0]);
      check($sformatf("reset%0d.valid", b), o.valid, 0);
      check_out($sformatf("reset%0d", b), o, 8'h00, 0, 0, 0, 0);
    end
    @(posedge clk); #1;
    drive_bit(0, 1'b1, 32);

    // 8N1 0xA5: latency from start edge and single-cycle valid pulse.
    fork
      send_frame(0, 8'hA5, 0, 0, 1);
      begin
        wait_valid(0, 400, got, o, t_rise);
        check("a5.got_valid", got, 1);
        if (got) begin
          check_out("a5", o, 8'hA5, 0, 0, 0, 0);
          lat = int'((t_rise - t_start - 4) / 10);
          check("a5.latency_in_155_157", (lat >= 155 && lat <= 157), 1);
          @(negedge clk);
          check("a5.pulse_one_clk", val_a, 0);
        end
      end
    join
    drive_bit(0, 1'b1, 32);

    for (int i = 0; i < 8; i++) begin
      xfer(1, vecs[i].data, 1, vecs[i].par, vecs[i].stop, $sformatf("vec%0d", i),
           vecs[i].e_perr, vecs[i].e_ferr, vecs[i].e_brk);
      drive_bit(1, 1'b1, 32);
    end

    // Short glitch must be rejected as a false start.
    drive_bit(0, 1'b0, 6);
    drive_bit(0, 1'b1, 1);
    expect_quiet(0, 48, "glitch.no_valid");
    @(posedge clk); #1;
    drive_bit(0, 1'b1, 16);
    xfer(0, 8'h3C, 0, 0, 1, "after_glitch", 0, 0, 0);
    drive_bit(0, 1'b1, 32);

    // Break: line low for 12 bit times, no retrigger while low or after it rises.
    fork
      begin
        drive_bit(0, 1'b0, 192);
        drive_bit(0, 1'b1, 1);
      end
      begin
        wait_valid(0, 400, got, o, t_rise);
        check("brk.got_valid", got, 1);
        if (got) check_out("brk", o, 8'h00, 0, 1, 1, 0);
        expect_quiet(0, 60, "brk.stuck_low_no_retrigger");
      end
    join
    @(posedge clk); #1;
    expect_quiet(0, 40, "brk.idle_no_frame");
    @(posedge clk); #1;
    xfer(0, 8'h5A, 0, 0, 1, "after_brk", 0, 0, 0);
    drive_bit(0, 1'b1, 32);

    // Overrun: consumer stalled over two back-to-back frames.
    rdy_a = 1'b0;
    send_frame(0, 8'h11, 0, 0, 1);
    send_frame(0, 8'h22, 0, 0, 1);
    drive_bit(0, 1'b1, 4);
    @(negedge clk);
    o = sample_out(0);
    check("ovr.valid_held", o.valid, 1);
    check_out("ovr", o, 8'h11, 0, 0, 0, 1);
    @(posedge clk); #1 rdy_a = 1'b1;
    @(posedge clk); #1 rdy_a = 1'b0;
    @(negedge clk);
    check("ovr.valid_after_accept", val_a, 0);
    check("ovr.overrun_after_accept", ov_a, 0);
    @(posedge clk); #1;
    drive_bit(0, 1'b1, 16);

    // Reset in the middle of data bit 7 of 0x55 while an older word is still held.
    send_frame(0, 8'h33, 0, 0, 1);
    drive_bit(0, 1'b1, 8);
    check("rst.held_valid", val_a, 1);
    check("rst.held_data", data_a, 8'h33);
    fork
      send_frame(0, 8'h55, 0, 0, 1);
      begin
        repeat (136) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        o = sample_out(0);
        check("rst.valid", o.valid, 0);
        check_out("rst", o, 8'h00, 0, 0, 0, 0);
      end
    join
    rdy_a = 1'b1;
    expect_quiet(0, 48, "rst.partial_no_output");
    @(posedge clk); #1;
    drive_bit(0, 1'b1, 16);
    xfer(0, 8'h99, 0, 0, 1, "after_rst", 0, 0, 0);
    drive_bit(0, 1'b1, 16);

    // Randomized frames on both instances against the frame-level model.
    for (int i = 0; i < 24; i++) begin
      bit         b, pe, pb, sb, ep, ef, ek;
      logic [7:0] d;
      int         gap;
      b  = i[0];
      pe = b;
      d  = (i % 5 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 3) != 0);
      pb = ^d;
      if ($urandom_range(0, 2) == 0) pb = ~pb;
      ep = pe && (pb != ^d);
      ef = !sb;
      ek = (d == 8'h00) && (!pe || !pb) && !sb;
      xfer(b, d, pe, pb, sb, $sformatf("rand%0d", i), ep, ef, ek);
      gap = sb ? int'($urandom_range(0, 20)) : 4 + int'($urandom_range(0, 20));
      if (gap > 0) drive_bit(b, 1'b1, gap);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
